// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. Operands are captured on a start request and
//   consumed DIGIT bits per clock through a small ripple slice, with the carry
//   held in a register between digits. Results are published all at once when
//   the last digit has been processed, so the outputs never show partial sums.
//
// Parameters
//   WIDTH : operand/result width in bits (>= 2)
//   DIGIT : bits processed per clock; WIDTH must be a multiple of DIGIT
//
// Ports
//   i_clk      : clock, rising-edge active
//   i_rst      : asynchronous active-high reset
//   i_start    : start request, honoured only when not busy
//   i_sub      : 0 = A+B, 1 = A-B (captured with i_start)
//   i_a, i_b   : operands (captured with i_start)
//   o_busy     : high while an operation is in progress
//   o_done     : one-cycle pulse when the result outputs update
//   o_sum      : result modulo 2^WIDTH
//   o_carry    : carry out of the MSB (subtract: 1 = no borrow)
//   o_overflow : two's-complement signed overflow

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  // Bad parameter combinations are caught at elaboration time.
  generate
    if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_cfgError
      $error("serial_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_aMsb;
  logic             r_bMsb;

  logic [WIDTH-1:0] w_bIn;
  logic [DIGIT:0]   w_digitSum;
  logic [WIDTH-1:0] w_shiftNext;

  // Subtraction is A + ~B + 1; the +1 arrives through the carry-in.
  assign w_bIn = i_sub ? ~i_b : i_b;

  assign w_digitSum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, r_carry};

  // Each new digit enters at the top, so after N steps the first digit has
  // walked down to bit 0 and the register holds the completed sum.
  assign w_shiftNext = (r_shift >> DIGIT)
                     | (WIDTH'(w_digitSum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_shift    <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_aMsb     <= 1'b0;
      r_bMsb     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= w_bIn;
            r_shift <= '0;
            r_carry <= i_sub;
            r_cnt   <= CW'(N);
            // Operand sign bits are shifted out during RUN, so keep them
            // aside for the overflow decision at the end.
            r_aMsb  <= i_a[WIDTH-1];
            r_bMsb  <= w_bIn[WIDTH-1];
            o_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end

        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_shift <= w_shiftNext;
          r_carry <= w_digitSum[DIGIT];
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            o_sum      <= w_shiftNext;
            o_carry    <= w_digitSum[DIGIT];
            o_overflow <= (r_aMsb == r_bMsb) && (w_shiftNext[WIDTH-1] != r_aMsb);
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            r_state    <= DONE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. Two instances are exercised: one with
// DIGIT=1 and one with DIGIT=4, both WIDTH=8. Expected results come from a
// whole-word reference model and are queued when a start is driven; monitors
// pop and compare them whenever o_done pulses.

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic       start1, sub1;
  logic [7:0] a1, b1;
  logic       busy1, done1, carry1, ovf1;
  logic [7:0] sum1;

  logic       start4, sub4;
  logic [7:0] a4, b4;
  logic       busy4, done4, carry4, ovf4;
  logic [7:0] sum4;

  int checks = 0;
  int errors = 0;

  logic [9:0] q1[$];
  logic [9:0] q4[$];
  logic [7:0] heldSum1 = 8'h00;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_sub(sub1),
    .i_a(a1), .i_b(b1), .o_busy(busy1), .o_done(done1),
    .o_sum(sum1), .o_carry(carry1), .o_overflow(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_sub(sub4),
    .i_a(a4), .i_b(b4), .o_busy(busy4), .o_done(done4),
    .o_sum(sum4), .o_carry(carry4), .o_overflow(ovf4)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Whole-word reference: returns {overflow, carry, sum[7:0]}.
  function automatic logic [9:0] refModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub);
    logic [7:0] bEff;
    logic [8:0] full;
    logic       ovf;
    bEff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bEff} + {8'd0, sub};
    ovf  = (a[7] == bEff[7]) && (full[7] != a[7]);
    return {ovf, full[8], full[7:0]};
  endfunction

  // Drives a start request on the selected instance (1 or 4) and queues the
  // expected result. Called on a falling edge; waitDone releases i_start.
  task automatic applyStimulus(input int sel, input logic [7:0] a, input logic [7:0] b,
                               input logic sub);
    if (sel == 1) begin
      start1 = 1'b1; a1 = a; b1 = b; sub1 = sub;
      q1.push_back(refModel(a, b, sub));
    end else begin
      start4 = 1'b1; a4 = a; b4 = b; sub4 = sub;
      q4.push_back(refModel(a, b, sub));
    end
  endtask

  // Lets the start edge pass, then samples every falling edge until o_done.
  // doneAt is the number of edges after the start edge (-1 on timeout);
  // returns on the falling edge of the DONE cycle.
  task automatic waitDone(input int sel, output int busyCycles, output int doneAt);
    busyCycles = 0;
    doneAt     = -1;
    @(posedge clk);
    #1;
    if (sel == 1) start1 = 1'b0; else start4 = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      if ((sel == 1) ? done1 : done4) begin
        doneAt = c;
        break;
      end
      if ((sel == 1) ? busy1 : busy4) busyCycles++;
    end
  endtask

  // Scoreboard for the DIGIT=1 instance.
  always @(negedge clk) begin
    logic [9:0] exp1;
    if (!rst && done1) begin
      checkOutput("sb1_pending", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        exp1 = q1.pop_front();
        checkOutput("sb1_sum",   32'(sum1),   32'(exp1[7:0]));
        checkOutput("sb1_carry", 32'(carry1), 32'(exp1[8]));
        checkOutput("sb1_ovf",   32'(ovf1),   32'(exp1[9]));
        heldSum1 = exp1[7:0];
      end
    end
  end

  // Scoreboard for the DIGIT=4 instance.
  always @(negedge clk) begin
    logic [9:0] exp4;
    if (!rst && done4) begin
      checkOutput("sb4_pending", 32'(q4.size() > 0), 1);
      if (q4.size() > 0) begin
        exp4 = q4.pop_front();
        checkOutput("sb4_sum",   32'(sum4),   32'(exp4[7:0]));
        checkOutput("sb4_carry", 32'(carry4), 32'(exp4[8]));
        checkOutput("sb4_ovf",   32'(ovf4),   32'(exp4[9]));
      end
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    int busyCycles, doneAt, doneCount;
    logic [7:0] ta[4];
    logic [7:0] tb[4];
    logic       ts[4];
    logic [9:0] te[4];

    ta = '{8'hFF, 8'h7F, 8'h05, 8'h80};
    tb = '{8'h01, 8'h01, 8'h07, 8'h01};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1};
    te = '{10'h100, 10'h280, 10'h0FE, 10'h37F};

    rst = 1'b1;
    start1 = 1'b0; sub1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
    start4 = 1'b0; sub4 = 1'b0; a4 = 8'h00; b4 = 8'h00;

    // Reset state on both instances.
    #1;
    checkOutput("rst1_flags", 32'({busy1, done1, carry1, ovf1}), 0);
    checkOutput("rst1_sum",   32'(sum1), 0);
    checkOutput("rst4_flags", 32'({busy4, done4, carry4, ovf4}), 0);
    checkOutput("rst4_sum",   32'(sum4), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 0x0F + 0x01: busy for 8 cycles, done 8 edges after start.
    applyStimulus(1, 8'h0F, 8'h01, 1'b0);
    waitDone(1, busyCycles, doneAt);
    checkOutput("add0f_busyCycles", busyCycles, 8);
    checkOutput("add0f_latency",    doneAt, 8);
    checkOutput("add0f_busyAtDone", 32'(busy1), 0);
    checkOutput("add0f_sum",        32'(sum1), 32'h10);
    @(negedge clk);
    checkOutput("add0f_donePulse",  32'(done1), 0);

    // Add/subtract boundary cases, cross-checked against hand values.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, ta[i], tb[i], ts[i]);
      waitDone(1, busyCycles, doneAt);
      checkOutput($sformatf("tbl%0d_latency", i), doneAt, 8);
      checkOutput($sformatf("tbl%0d_result", i), 32'({ovf1, carry1, sum1}), 32'(te[i]));
      @(negedge clk);
    end

    // Start pulsed in RUN must be ignored; old result held meanwhile.
    applyStimulus(1, 8'h10, 8'h20, 1'b0);
    @(posedge clk);
    #1 start1 = 1'b0;
    doneCount = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (done1) doneCount++;
      else if (busy1) checkOutput("ign_holdSum", 32'(sum1), 32'(heldSum1));
      if (c == 2) begin
        start1 = 1'b1; a1 = 8'hAA; b1 = 8'h55;
      end
      if (c == 3) start1 = 1'b0;
    end
    checkOutput("ign_doneCount", doneCount, 1);
    checkOutput("ign_sum",       32'(sum1), 32'h30);

    // Asynchronous reset mid-RUN, between clock edges.
    applyStimulus(1, 8'h33, 8'h44, 1'b0);
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_flags", 32'({busy1, done1, carry1, ovf1}), 0);
    checkOutput("midrst_sum",   32'(sum1), 0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done1 || busy1) doneCount++;
    end
    checkOutput("midrst_noDone", doneCount, 0);
    applyStimulus(1, 8'h01, 8'h01, 1'b0);
    waitDone(1, busyCycles, doneAt);
    checkOutput("postrst_latency", doneAt, 8);
    checkOutput("postrst_sum",     32'(sum1), 32'h02);
    @(negedge clk);

    // DIGIT=4: two-edge latency and a back-to-back start held in DONE.
    applyStimulus(4, 8'h99, 8'h99, 1'b0);
    waitDone(4, busyCycles, doneAt);
    checkOutput("d4a_busyCycles", busyCycles, 2);
    checkOutput("d4a_latency",    doneAt, 2);
    checkOutput("d4a_result",     32'({carry4, sum4}), 32'h132);
    applyStimulus(4, 8'h01, 8'h02, 1'b0);
    waitDone(4, busyCycles, doneAt);
    checkOutput("d4b_busyCycles", busyCycles, 2);
    checkOutput("d4b_latency",    doneAt, 2);
    checkOutput("d4b_sum",        32'(sum4), 32'h03);

    repeat (3) @(negedge clk);
    checkOutput("q1_drained", q1.size(), 0);
    checkOutput("q4_drained", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
